// File: rtl/log2_32_iter.sv
// Walks a 32-bit mask one set bit per cycle, emitting index, one-hot value and beat ordinal.
// Empty masks produce a single marker beat; back-to-back masks run without a bubble.
module log2_32_iter #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] InMask,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [4:0]  OutIndex,
  output logic [31:0] OutOnehot,
  output logic [4:0]  OutSeq,
  output logic        OutLast,
  output logic        OutEmpty
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pending;
  logic [4:0]  seq;
  logic [31:0] sel;
  logic        run;

  function automatic logic [31:0] reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [31:0] lowest_bit(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

  function automatic logic [4:0] encode5(input logic [31:0] onehot);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++)
      if (onehot[i]) idx = idx | 5'(i);
    return idx;
  endfunction

  // Descending order reuses the lowest-bit trick on the bit-reversed mask.
  always_comb begin
    sel       = LSB_FIRST ? lowest_bit(pending) : reverse32(lowest_bit(reverse32(pending)));
    run       = (state == RUN);
    OutValid  = run;
    OutOnehot = run ? sel : 32'd0;
    OutIndex  = run ? encode5(sel) : 5'd0;
    OutSeq    = run ? seq : 5'd0;
    OutLast   = run & ((pending & (pending - 32'd1)) == 32'd0);
    OutEmpty  = run & (pending == 32'd0);
    InReady   = nReset & (~run | (OutLast & OutReady));
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      pending <= '0;
      seq     <= '0;
    end else if (!run) begin
      if (InValid) begin
        pending <= InMask;
        seq     <= '0;
        state   <= RUN;
      end
    end else if (OutReady) begin
      if (!OutLast) begin
        pending <= pending & ~sel;
        seq     <= seq + 5'd1;
      end else if (InValid) begin
        pending <= InMask;
        seq     <= '0;
      end else begin
        pending <= '0;
        state   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_log2_32_iter.sv
// Bench for log2_32_iter: both bit orders driven in lockstep and compared to a set-bit list model.
module tb_log2_32_iter;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        InValid = 1'b0;
  logic [31:0] InMask = '0;
  logic        OutReady = 1'b0;

  logic        a_in_ready, a_valid, a_last, a_empty;
  logic [4:0]  a_index, a_seq;
  logic [31:0] a_onehot;
  logic        d_in_ready, d_valid, d_last, d_empty;
  logic [4:0]  d_index, d_seq;
  logic [31:0] d_onehot;

  int tests = 0;
  int failed = 0;

  always #5 Clk = ~Clk;

  log2_32_iter #(.LSB_FIRST(1'b1)) dut_asc (
    .Clk(Clk), .nReset(nReset), .InValid(InValid), .InReady(a_in_ready), .InMask(InMask),
    .OutValid(a_valid), .OutReady(OutReady), .OutIndex(a_index), .OutOnehot(a_onehot),
    .OutSeq(a_seq), .OutLast(a_last), .OutEmpty(a_empty)
  );

  log2_32_iter #(.LSB_FIRST(1'b0)) dut_desc (
    .Clk(Clk), .nReset(nReset), .InValid(InValid), .InReady(d_in_ready), .InMask(InMask),
    .OutValid(d_valid), .OutReady(OutReady), .OutIndex(d_index), .OutOnehot(d_onehot),
    .OutSeq(d_seq), .OutLast(d_last), .OutEmpty(d_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " asc valid"}, 32'(a_valid), 32'd0);
    chk({tag, " desc valid"}, 32'(d_valid), 32'd0);
    chk({tag, " asc in_ready"}, 32'(a_in_ready), 32'd1);
    chk({tag, " desc in_ready"}, 32'(d_in_ready), 32'd1);
  endtask

  // Called at a falling edge while idle; the mask is taken on the next rising edge.
  task automatic load(input logic [31:0] mask);
    InValid = 1'b1;
    InMask  = mask;
    #1;
    chk("load in_ready asc", 32'(a_in_ready), 32'd1);
    chk("load in_ready desc", 32'(d_in_ready), 32'd1);
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  // Consumes every beat of an already-loaded mask with random stalls; optionally
  // presents next_mask during the final beat so it is taken without a bubble.
  task automatic walk(input logic [31:0] mask, input int stall_pct,
                      input bit chain, input logic [31:0] next_mask);
    int asc[$];
    int desc[$];
    int n, b, stalls;
    bit rdy, last, empty;
    logic [4:0] ia, id;
    for (int i = 0; i < 32; i++) if (mask[i]) asc.push_back(i);
    for (int i = 31; i >= 0; i--) if (mask[i]) desc.push_back(i);
    empty = (asc.size() == 0);
    n = empty ? 1 : asc.size();
    b = 0;
    stalls = 0;
    while (b < n) begin
      last = (b == n - 1);
      ia = empty ? 5'd0 : 5'(asc[b]);
      id = empty ? 5'd0 : 5'(desc[b]);
      chk("asc valid", 32'(a_valid), 32'd1);
      chk("asc index", 32'(a_index), 32'(ia));
      chk("asc onehot", a_onehot, empty ? 32'd0 : (32'd1 << ia));
      chk("asc seq", 32'(a_seq), 32'(b));
      chk("asc last", 32'(a_last), 32'(last));
      chk("asc empty", 32'(a_empty), 32'(empty));
      chk("desc valid", 32'(d_valid), 32'd1);
      chk("desc index", 32'(d_index), 32'(id));
      chk("desc onehot", d_onehot, empty ? 32'd0 : (32'd1 << id));
      chk("desc seq", 32'(d_seq), 32'(b));
      chk("desc last", 32'(d_last), 32'(last));
      chk("desc empty", 32'(d_empty), 32'(empty));
      rdy = ($urandom_range(99) >= stall_pct) || (stalls >= 4);
      stalls = rdy ? 0 : stalls + 1;
      InValid  = last && chain;
      InMask   = next_mask;
      OutReady = rdy;
      #1;
      chk("beat in_ready asc", 32'(a_in_ready), 32'(rdy && last));
      chk("beat in_ready desc", 32'(d_in_ready), 32'(rdy && last));
      @(negedge Clk);
      if (rdy) b++;
    end
    InValid  = 1'b0;
    OutReady = 1'b0;
    if (!chain) begin
      #1;
      chk_idle("after walk");
    end
  endtask

  initial begin
    logic [31:0] m, nm;
    bit ch;
    // Reset: everything low, including InReady, even with a request pending.
    InValid = 1'b1;
    InMask  = 32'hFFFF_FFFF;
    OutReady = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset asc valid", 32'(a_valid), 32'd0);
    chk("reset asc in_ready", 32'(a_in_ready), 32'd0);
    chk("reset desc in_ready", 32'(d_in_ready), 32'd0);
    chk("reset asc outputs", {a_onehot}, 32'd0);
    chk("reset asc index/seq/last/empty", {22'd0, a_index, a_seq, a_last, a_empty}, 32'd0);
    InValid = 1'b0;
    OutReady = 1'b0;
    nReset = 1'b1;
    #1;
    chk_idle("post reset");
    @(negedge Clk);

    // Empty mask
    load(32'h0000_0000);
    walk(32'h0000_0000, 0, 1'b0, 32'd0);

    // Sparse mask, both orders, no stalls
    load(32'h8000_0421);
    chk("directed asc first onehot", a_onehot, 32'h0000_0001);
    chk("directed desc first index", 32'(d_index), 32'd31);
    walk(32'h8000_0421, 0, 1'b0, 32'd0);

    // Full mask chained straight into 0x2
    load(32'hFFFF_FFFF);
    walk(32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0002);
    walk(32'h0000_0002, 0, 1'b0, 32'd0);

    // Backpressure
    load(32'h0F0F_0000);
    walk(32'h0F0F_0000, 50, 1'b0, 32'd0);

    // Random masks, random stalls, some chained
    m = $urandom;
    load(m);
    for (int t = 0; t < 8; t++) begin
      nm = (t % 3 == 1) ? 32'd0 : (($urandom_range(1) == 1) ? $urandom : (32'd1 << $urandom_range(31)));
      ch = (t != 7) && ($urandom_range(1) == 1);
      walk(m, 30, ch, nm);
      if (!ch && t != 7) load(nm);
      m = nm;
    end

    // Reset mid-walk during beat Seq=2 of 0xFF
    load(32'h0000_00FF);
    OutReady = 1'b1;
    repeat (2) @(negedge Clk);
    chk("pre-abort seq", 32'(a_seq), 32'd2);
    OutReady = 1'b0;
    #2 nReset = 1'b0;
    #1;
    chk("abort asc valid", 32'(a_valid), 32'd0);
    chk("abort desc valid", 32'(d_valid), 32'd0);
    chk("abort in_ready", 32'(a_in_ready), 32'd0);
    @(negedge Clk);
    nReset = 1'b1;
    #1;
    chk_idle("after abort");
    @(negedge Clk);
    chk_idle("idle after abort");
    load(32'h0000_0010);
    walk(32'h0000_0010, 0, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
